ff_page_bus: RTL and testbench

- Bus responder for the CPU high page $FF00–$FFFF: the stage directly downstream of the CPU bus interface that supplies read data for LD A,(C), LDH and similar accesses.
- Holds 127-byte HRAM ($FF80–$FFFE) and the IE register ($FFFF).
- Forwards $FF00–$FF7F to the I/O peripheral fabric over a req/ack handshake.
- Tracks T-cycles T1..T4 from a per-M-cycle start pulse and returns data on the T-cycle grid the CPU expects.

---
 rtl/ff_page_pkg.sv | 25 ++
 rtl/ff_page_bus_if.sv | 37 +++
 rtl/ff_page_hram.sv | 29 ++
 rtl/ff_page_bus.sv | 141 ++++++++++++++
 tb/tb_ff_page_bus.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/ff_page_pkg.sv
// ff_page_pkg: shared types and constants for the CPU high-page ($FF00-$FFFF)
// bus responder.
//   tphase_t   : T-cycle phase within an M-cycle (IDLE, T1..T4)
//   region_t   : decoded target of a latched high-page access
//   PAGE_HI    : upper address byte that selects the high page
//   IE_ADR     : address of the interrupt-enable register
//   next_phase : free-running T-cycle sequence (T4 falls back to IDLE)
package ff_page_pkg;

  typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} tphase_t;
  typedef enum logic [1:0] {NONE, IO, HRAM, IE} region_t;

  localparam logic [7:0]  PAGE_HI = 8'hff;
  localparam logic [15:0] IE_ADR  = 16'hffff;

  function automatic tphase_t next_phase(input tphase_t p);
    case (p)
      T1:      return T2;
      T2:      return T3;
      T3:      return T4;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ff_page_bus_if.sv
// ff_page_bus_if: CPU-side and I/O-fabric-side signals of the high-page
// responder, bundled together.
//   CPU side : mcyc_start, cpu_adr, cpu_rd, cpu_wr, cpu_dout -> responder
//              cpu_din, cpu_sel                              <- responder
//   I/O side : io_req, io_wr, io_adr, io_wdata, io_timeout    <- responder
//              io_rdata, io_ack                              -> responder
//   IRQ side : ie (IE register contents)                      <- responder
// Modports: master = CPU + I/O fabric, slave = the responder.
interface ff_page_bus_if #(parameter int IE_WIDTH = 8);

  logic                mcyc_start;
  logic [15:0]         cpu_adr;
  logic                cpu_rd;
  logic                cpu_wr;
  logic [7:0]          cpu_dout;
  logic [7:0]          cpu_din;
  logic                cpu_sel;
  logic                io_req;
  logic                io_wr;
  logic [6:0]          io_adr;
  logic [7:0]          io_wdata;
  logic [7:0]          io_rdata;
  logic                io_ack;
  logic                io_timeout;
  logic [IE_WIDTH-1:0] ie;

  modport master (
    output mcyc_start, cpu_adr, cpu_rd, cpu_wr, cpu_dout, io_rdata, io_ack,
    input  cpu_din, cpu_sel, io_req, io_wr, io_adr, io_wdata, io_timeout, ie
  );

  modport slave (
    input  mcyc_start, cpu_adr, cpu_rd, cpu_wr, cpu_dout, io_rdata, io_ack,
    output cpu_din, cpu_sel, io_req, io_wr, io_adr, io_wdata, io_timeout, ie
  );

endinterface

// File: rtl/ff_page_hram.sv
// ff_page_hram: 127 x 8 high RAM ($FF80-$FFFE), single read/write port,
// registered read. Offset 7'h7f is the IE register and is never stored here.
//   clk_i   : clock
//   re_i    : read enable, rdata_o updates on the next edge
//   we_i    : write enable
//   addr_i  : byte offset (address bits [6:0])
//   wdata_i : write data
//   rdata_o : registered read data
// Contents are not reset.
module ff_page_hram (
  input  logic       clk_i,
  input  logic       re_i,
  input  logic       we_i,
  input  logic [6:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [0:126];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i && (addr_i != 7'h7f)) mem_q[addr_i] <= wdata_i;
    if (re_i && (addr_i != 7'h7f)) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ff_page_bus.sv
// ff_page_bus: responder for CPU accesses to $FF00-$FFFF. Holds HRAM and IE,
// forwards $FF00-$FF7F to the I/O fabric over req/ack, and returns read data
// on the CPU T-cycle grid.
//   clk, reset : clock (one T-cycle per clock), async active-high reset
//   bus        : ff_page_bus_if.slave (CPU, I/O fabric and IE signals)
//   boot_lock  : sticky boot-ROM lock, present only with FF_PAGE_BOOT_LOCK_EN
// Optional feature macro: FF_PAGE_BOOT_LOCK_EN decodes $FF50 internally.
module ff_page_bus
  import ff_page_pkg::*;
#(
  parameter logic [7:0] OPEN_BUS = 8'hff,
  parameter int         IE_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
`ifdef FF_PAGE_BOOT_LOCK_EN
  output logic boot_lock,
`endif
  ff_page_bus_if.slave bus
);

  tphase_t             phase_q, phase_d, tph;
  region_t             region_q, region_d;
  logic                sel_q, sel_d, wr_q, boot_q, boot_d, acked_q;
  logic [6:0]          adr_q;
  logic [7:0]          wdata_q, rdata_q, din_q;
  logic                timeout_q, timeout_d;
  logic [IE_WIDTH-1:0] ie_q;
  logic                io_rd_win, io_req_c, ack_now, boot_hit;
  logic                ram_re, ram_we;
  logic [6:0]          ram_addr;
  logic [7:0]          ram_rdata, ie_rd, boot_rd;

`ifdef FF_PAGE_BOOT_LOCK_EN
  logic boot_lock_q;
  assign boot_hit = (bus.cpu_adr[7:0] == 8'h50);
  assign boot_rd  = {7'h7f, boot_lock_q};
  assign boot_lock = boot_lock_q;
`else
  assign boot_hit = 1'b0;
  assign boot_rd  = 8'hff;
`endif

  // Phase state register: phase_q is the phase scheduled for this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase_q <= IDLE;
    else       phase_q <= phase_d;
  end

  // mcyc_start overrides the schedule so a new M-cycle aborts whatever was
  // in flight within the same cycle.
  always_comb begin
    tph       = bus.mcyc_start ? T1 : phase_q;
    phase_d   = next_phase(tph);
    sel_d     = (bus.cpu_adr[15:8] == PAGE_HI) && (bus.cpu_rd || bus.cpu_wr);
    boot_d    = sel_d && boot_hit;
    region_d  = NONE;
    if (sel_d) begin
      if (bus.cpu_adr == IE_ADR) region_d = IE;
      else if (bus.cpu_adr[7])   region_d = HRAM;
      else if (!boot_hit)        region_d = IO;
    end
    io_rd_win = (region_q == IO) && !wr_q && ((tph == T2) || (tph == T3));
    io_req_c  = (io_rd_win && !acked_q) || ((region_q == IO) && wr_q && (tph == T4));
    ack_now   = io_rd_win && !acked_q && bus.io_ack;
    timeout_d = (tph == T3) && io_rd_win && !acked_q && !bus.io_ack;
    ram_re    = (tph == T1);
    ram_we    = (tph == T4) && (region_q == HRAM) && wr_q;
    ram_addr  = ram_we ? adr_q : bus.cpu_adr[6:0];
    ie_rd     = 8'hff;
    ie_rd[IE_WIDTH-1:0] = ie_q;
  end

  // T1 -> T2: latch access; T2 -> T3: internal read data; T3 -> T4: I/O read
  // data and write data; T4 exit: internal register writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      region_q  <= NONE;
      sel_q     <= 1'b0;
      wr_q      <= 1'b0;
      boot_q    <= 1'b0;
      acked_q   <= 1'b0;
      adr_q     <= 7'h00;
      wdata_q   <= 8'h00;
      din_q     <= OPEN_BUS;
      timeout_q <= 1'b0;
      ie_q      <= '0;
    end else begin
      timeout_q <= timeout_d;
      if (tph == T1) begin
        sel_q    <= sel_d;
        wr_q     <= bus.cpu_wr;  // rd+wr together counts as a write
        region_q <= region_d;
        boot_q   <= boot_d;
        adr_q    <= bus.cpu_adr[6:0];
        acked_q  <= 1'b0;
      end
      if (ack_now) acked_q <= 1'b1;
      if ((tph == T2) && !wr_q) begin
        if (region_q == HRAM)    din_q <= ram_rdata;
        else if (region_q == IE) din_q <= ie_rd;
        else if (boot_q)         din_q <= boot_rd;
      end
      if ((tph == T3) && (region_q == IO) && !wr_q)
        din_q <= ack_now ? bus.io_rdata : (acked_q ? rdata_q : OPEN_BUS);
      if ((tph == T3) && sel_q && wr_q) wdata_q <= bus.cpu_dout;
      if ((tph == T4) && (region_q == IE) && wr_q) ie_q <= wdata_q[IE_WIDTH-1:0];
    end
  end

  // Ack in T2 is held here until cpu_din is loaded at the T3 -> T4 edge.
  always_ff @(posedge clk) begin
    if (ack_now) rdata_q <= bus.io_rdata;
  end

`ifdef FF_PAGE_BOOT_LOCK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) boot_lock_q <= 1'b0;
    else if ((tph == T4) && boot_q && wr_q && (wdata_q != 8'h00)) boot_lock_q <= 1'b1;
  end
`endif

  ff_page_hram u_hram (
    .clk_i   (clk),
    .re_i    (ram_re),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign bus.cpu_din    = din_q;
  assign bus.cpu_sel    = sel_q;
  assign bus.io_req     = io_req_c;
  assign bus.io_wr      = io_req_c && wr_q;
  assign bus.io_adr     = adr_q;
  assign bus.io_wdata   = wdata_q;
  assign bus.io_timeout = timeout_q;
  assign bus.ie         = ie_q;

endmodule

// File: tb/tb_ff_page_bus.sv
// tb_ff_page_bus: directed bench for ff_page_bus (IE_WIDTH = 5).
module tb_ff_page_bus;

  logic clk = 1'b0;
  logic reset;
  int   npass = 0;
  int   nfail = 0;
  int   ntot  = 0;

  always #5 clk = ~clk;

  ff_page_bus_if #(.IE_WIDTH(5)) bus ();

`ifdef FF_PAGE_BOOT_LOCK_EN
  logic boot_lock;
`endif

  ff_page_bus #(.OPEN_BUS(8'hff), .IE_WIDTH(5)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef FF_PAGE_BOOT_LOCK_EN
    .boot_lock (boot_lock),
`endif
    .bus       (bus)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives T1 of an M-cycle and returns settled inside T2.
  task automatic start_mc(input logic [15:0] a, input logic rd, input logic wr);
    bus.mcyc_start = 1'b1;
    bus.cpu_adr    = a;
    bus.cpu_rd     = rd;
    bus.cpu_wr     = wr;
    cyc();
    bus.mcyc_start = 1'b0;
    bus.cpu_adr    = 16'h0000;
    bus.cpu_rd     = 1'b0;
    bus.cpu_wr     = 1'b0;
    #1;
  endtask

  // Full write M-cycle; returns in the idle cycle after the T4 exit edge.
  task automatic write_mc(input logic [15:0] a, input logic [7:0] d);
    start_mc(a, 1'b0, 1'b1);
    cyc();
    bus.cpu_dout = d;
    #1;
    cyc();
    bus.cpu_dout = 8'h00;
    #1;
    cyc();
  endtask

  initial begin
    reset          = 1'b1;
    bus.mcyc_start = 1'b0;
    bus.cpu_adr    = 16'h0000;
    bus.cpu_rd     = 1'b0;
    bus.cpu_wr     = 1'b0;
    bus.cpu_dout   = 8'h00;
    bus.io_rdata   = 8'h00;
    bus.io_ack     = 1'b0;
    cyc();
    cyc();
    chk("rst_din",     bus.cpu_din,    8'hff);
    chk("rst_sel",     bus.cpu_sel,    1'b0);
    chk("rst_req",     bus.io_req,     1'b0);
    chk("rst_iowr",    bus.io_wr,      1'b0);
    chk("rst_timeout", bus.io_timeout, 1'b0);
    chk("rst_ie",      bus.ie,         5'h00);
    reset = 1'b0;
    cyc();

    // HRAM write $FF90 <- 5a, then read it back
    start_mc(16'hff90, 1'b0, 1'b1);
    chk("hw_sel", bus.cpu_sel, 1'b1);
    chk("hw_req_t2", bus.io_req, 1'b0);
    cyc();
    bus.cpu_dout = 8'h5a;
    #1;
    chk("hw_req_t3", bus.io_req, 1'b0);
    cyc();
    bus.cpu_dout = 8'h00;
    #1;
    chk("hw_req_t4", bus.io_req, 1'b0);
    chk("hw_wdata", bus.io_wdata, 8'h5a);
    cyc();
    start_mc(16'hff90, 1'b1, 1'b0);
    chk("hr_req_t2", bus.io_req, 1'b0);
    chk("hr_din_t2_old", bus.cpu_din, 8'hff);
    cyc();
    chk("hr_din_t3", bus.cpu_din, 8'h5a);
    cyc();
    chk("hr_din_t4", bus.cpu_din, 8'h5a);
    chk("hr_req_t4", bus.io_req, 1'b0);
    cyc();

    // IO read $FF44, ack in T3 with 91
    start_mc(16'hff44, 1'b1, 1'b0);
    chk("ior_req_t2", bus.io_req, 1'b1);
    chk("ior_wr_t2",  bus.io_wr,  1'b0);
    chk("ior_adr",    bus.io_adr, 7'h44);
    cyc();
    bus.io_ack   = 1'b1;
    bus.io_rdata = 8'h91;
    #1;
    chk("ior_req_t3", bus.io_req, 1'b1);
    cyc();
    bus.io_ack   = 1'b0;
    bus.io_rdata = 8'h00;
    #1;
    chk("ior_req_t4", bus.io_req, 1'b0);
    chk("ior_din_t4", bus.cpu_din, 8'h91);
    chk("ior_to_t4",  bus.io_timeout, 1'b0);
    cyc();
    chk("ior_req_idle", bus.io_req, 1'b0);

    // IO read $FF10 without ack -> open bus and one timeout pulse
    start_mc(16'hff10, 1'b1, 1'b0);
    cyc();
    cyc();
    chk("tmo_din_t4", bus.cpu_din, 8'hff);
    chk("tmo_pulse_t4", bus.io_timeout, 1'b1);
    cyc();
    chk("tmo_pulse_end", bus.io_timeout, 1'b0);

    // IO write $FF05 <- 3c, no ack
    start_mc(16'hff05, 1'b0, 1'b1);
    chk("iow_req_t2", bus.io_req, 1'b0);
    cyc();
    bus.cpu_dout = 8'h3c;
    #1;
    cyc();
    bus.cpu_dout = 8'h00;
    #1;
    chk("iow_req_t4",   bus.io_req,   1'b1);
    chk("iow_wr_t4",    bus.io_wr,    1'b1);
    chk("iow_wdata_t4", bus.io_wdata, 8'h3c);
    chk("iow_adr_t4",   bus.io_adr,   7'h05);
    cyc();
    chk("iow_req_idle", bus.io_req, 1'b0);
    chk("iow_no_tmo",   bus.io_timeout, 1'b0);

    // IE writes and reads with IE_WIDTH = 5
    write_mc(16'hffff, 8'h2a);
    chk("ie_2a", bus.ie, 5'h0a);
    start_mc(16'hffff, 1'b1, 1'b0);
    cyc();
    chk("ie_rd_ea", bus.cpu_din, 8'hea);
    cyc();
    cyc();
    write_mc(16'hffff, 8'hff);
    chk("ie_ff", bus.ie, 5'h1f);
    start_mc(16'hffff, 1'b1, 1'b0);
    cyc();
    chk("ie_rd_ff", bus.cpu_din, 8'hff);
    cyc();
    cyc();

    // Reset during T4 of an HRAM write: write dropped, old contents kept
    write_mc(16'hff80, 8'hc7);
    start_mc(16'hff80, 1'b0, 1'b1);
    cyc();
    bus.cpu_dout = 8'h33;
    #1;
    cyc();
    bus.cpu_dout = 8'h00;
    reset = 1'b1;
    #1;
    chk("mrst_din",   bus.cpu_din,    8'hff);
    chk("mrst_sel",   bus.cpu_sel,    1'b0);
    chk("mrst_req",   bus.io_req,     1'b0);
    chk("mrst_wdata", bus.io_wdata,   8'h00);
    chk("mrst_to",    bus.io_timeout, 1'b0);
    chk("mrst_ie",    bus.ie,         5'h00);
    cyc();
    reset = 1'b0;
    #1;
    cyc();
    start_mc(16'hff80, 1'b1, 1'b0);
    cyc();
    chk("mrst_hram_kept", bus.cpu_din, 8'hc7);
    cyc();
    cyc();

    // mcyc_start in T3 of an IO read aborts it; stray ack ignored
    start_mc(16'hff20, 1'b1, 1'b0);
    chk("abt_req_t2", bus.io_req, 1'b1);
    cyc();
    bus.mcyc_start = 1'b1;
    bus.cpu_adr    = 16'h1234;
    bus.cpu_rd     = 1'b1;
    bus.io_ack     = 1'b1;
    bus.io_rdata   = 8'h55;
    #1;
    chk("abt_req_drop", bus.io_req, 1'b0);
    cyc();
    bus.mcyc_start = 1'b0;
    bus.cpu_adr    = 16'h0000;
    bus.cpu_rd     = 1'b0;
    bus.io_ack     = 1'b0;
    bus.io_rdata   = 8'h00;
    #1;
    chk("abt_sel_off", bus.cpu_sel, 1'b0);
    chk("abt_req_t2",  bus.io_req,  1'b0);
    chk("abt_to_t2",   bus.io_timeout, 1'b0);
    cyc();
    chk("abt_to_t3",  bus.io_timeout, 1'b0);
    chk("abt_din_t3", bus.cpu_din, 8'hc7);
    cyc();
    chk("abt_to_t4",  bus.io_timeout, 1'b0);
    chk("abt_din_t4", bus.cpu_din, 8'hc7);
    cyc();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
